// File: rtl/pipe_stage_buf.sv
// Two-entry skid buffer carrying an opaque payload and halt flag between pipeline stages.
// Optional performance counters are compiled in with `define PIPE_STAGE_BUF_PERF_CNT_EN.
module pipe_stage_buf #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_halt,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_halt,
    output logic              halt_seen,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} stateT;

    stateT             stateQ, stateD;
    logic [DATA_W-1:0] mainDataQ, mainDataD, skidDataQ, skidDataD;
    logic              mainHaltQ, mainHaltD, skidHaltQ, skidHaltD;
    logic              haltPendingQ, haltPendingD;
    logic              haltSeenQ, haltSeenD;
    logic              inReadyQ, inReadyD;
    logic              acc, deq;

    assign out_valid = (stateQ != StEmpty);
    assign acc       = in_valid & inReadyQ;
    assign deq       = out_valid & out_ready;

    always_comb begin
        stateD       = stateQ;
        mainDataD    = mainDataQ;
        mainHaltD    = mainHaltQ;
        skidDataD    = skidDataQ;
        skidHaltD    = skidHaltQ;
        haltPendingD = haltPendingQ;
        // A dequeue coincident with flush is still a delivery.
        haltSeenD    = haltSeenQ | (deq & mainHaltQ);

        if (flush) begin
            stateD       = StEmpty;
            haltPendingD = 1'b0;
        end else begin
            if (acc && in_halt) begin
                haltPendingD = 1'b1;
            end
            case (stateQ)
                StEmpty: begin
                    if (acc) begin
                        stateD    = StOne;
                        mainDataD = in_data;
                        mainHaltD = in_halt;
                    end
                end
                StOne: begin
                    if (acc && !deq) begin
                        stateD    = StFull;
                        skidDataD = in_data;
                        skidHaltD = in_halt;
                    end else if (acc && deq) begin
                        mainDataD = in_data;
                        mainHaltD = in_halt;
                    end else if (deq) begin
                        stateD = StEmpty;
                    end
                end
                StFull: begin
                    if (deq) begin
                        stateD    = StOne;
                        mainDataD = skidDataQ;
                        mainHaltD = skidHaltQ;
                    end
                end
                default: stateD = StEmpty;
            endcase
        end

        // Registered ready computed from next state keeps out_ready off the input path.
        inReadyD = (stateD != StFull) & ~haltSeenD & ~haltPendingD;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stateQ       <= StEmpty;
            mainDataQ    <= '0;
            mainHaltQ    <= 1'b0;
            skidDataQ    <= '0;
            skidHaltQ    <= 1'b0;
            haltPendingQ <= 1'b0;
            haltSeenQ    <= 1'b0;
            inReadyQ     <= 1'b0;
        end else begin
            stateQ       <= stateD;
            mainDataQ    <= mainDataD;
            mainHaltQ    <= mainHaltD;
            skidDataQ    <= skidDataD;
            skidHaltQ    <= skidHaltD;
            haltPendingQ <= haltPendingD;
            haltSeenQ    <= haltSeenD;
            inReadyQ     <= inReadyD;
        end
    end

    assign in_ready  = inReadyQ;
    assign out_data  = mainDataQ;
    assign out_halt  = mainHaltQ;
    assign halt_seen = haltSeenQ;

    always_comb begin
        case (stateQ)
            StOne:   occupancy = 2'd1;
            StFull:  occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

`ifdef PIPE_STAGE_BUF_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stallCntQ, flushCntQ;

    // Both counters saturate at all-ones.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stallCntQ <= '0;
            flushCntQ <= '0;
        end else begin
            if (in_valid && !inReadyQ && !(&stallCntQ)) begin
                stallCntQ <= stallCntQ + CntOne;
            end
            if (flush && (stateQ != StEmpty) && !(&flushCntQ)) begin
                flushCntQ <= flushCntQ + CntOne;
            end
        end
    end

    assign stall_cnt = stallCntQ;
    assign flush_cnt = flushCntQ;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: pass-through, backpressure, flush, halt, async reset and
// payload width extremes (DATA_W = 1 and 1024 instances share the handshake controls).
module tb_pipe_stage_buf;

`ifdef PIPE_STAGE_BUF_PERF_CNT_EN
    localparam bit Perf = 1'b1;
`else
    localparam bit Perf = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST;
    logic          in_valid, in_halt, flush, out_ready;
    logic [127:0]  in_data;
    logic          in_ready, out_valid, out_halt, halt_seen;
    logic [127:0]  out_data;
    logic [1:0]    occupancy;
    logic [31:0]   stall_cnt, flush_cnt;

    logic          dataW1, outW1;
    logic [1023:0] dataW1024, outW1024;
    logic          rdyW1, vldW1, hltW1, seenW1;
    logic          rdyW1024, vldW1024, hltW1024, seenW1024;
    logic [1:0]    occW1, occW1024;
    logic [31:0]   stW1, flW1, stW1024, flW1024;

    int numChecks = 0;
    int numFail   = 0;

    always #5 CLK = ~CLK;

    pipe_stage_buf dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_halt(in_halt), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_halt(out_halt), .halt_seen(halt_seen),
        .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_stage_buf #(.DATA_W(1)) dutW1 (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(rdyW1), .in_data(dataW1),
        .in_halt(in_halt), .flush(flush), .out_valid(vldW1), .out_ready(out_ready),
        .out_data(outW1), .out_halt(hltW1), .halt_seen(seenW1),
        .occupancy(occW1), .stall_cnt(stW1), .flush_cnt(flW1)
    );

    pipe_stage_buf #(.DATA_W(1024)) dutW1024 (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(rdyW1024), .in_data(dataW1024),
        .in_halt(in_halt), .flush(flush), .out_valid(vldW1024), .out_ready(out_ready),
        .out_data(outW1024), .out_halt(hltW1024), .halt_seen(seenW1024),
        .occupancy(occW1024), .stall_cnt(stW1024), .flush_cnt(flW1024)
    );

    task automatic checkVal(input string tag, input logic [127:0] act, input logic [127:0] exp);
        numChecks++;
        if (act !== exp) begin
            numFail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; in_valid = 1'b0; in_halt = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_data = '0; dataW1 = 1'b0; dataW1024 = '0;
        tick();
        checkVal("rst_in_ready", in_ready, 0);
        checkVal("rst_out_valid", out_valid, 0);
        checkVal("rst_out_data", out_data, 0);
        checkVal("rst_occ", occupancy, 0);
        checkVal("rst_halt_seen", halt_seen, 0);
        checkVal("rst_stall", stall_cnt, 0);
        tick();
        RST = 1'b0;
        tick();
        checkVal("rel_in_ready", in_ready, 1);

        // Pass-through
        out_ready = 1'b1; in_valid = 1'b1;
        in_data = 128'h11; tick();
        checkVal("pt_d11", out_data, 128'h11);
        checkVal("pt_v11", out_valid, 1);
        checkVal("pt_occ11", occupancy, 1);
        in_data = 128'h22; tick();
        checkVal("pt_d22", out_data, 128'h22);
        checkVal("pt_rdy22", in_ready, 1);
        in_data = 128'h33; tick();
        checkVal("pt_d33", out_data, 128'h33);
        checkVal("pt_occ33", occupancy, 1);
        in_valid = 1'b0; tick();
        checkVal("pt_drain", out_valid, 0);

        // Backpressure
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 128'hA0; tick();
        checkVal("bp_occ1", occupancy, 1);
        in_data = 128'hA1; tick();
        checkVal("bp_occ2", occupancy, 2);
        checkVal("bp_rdy0", in_ready, 0);
        checkVal("bp_head", out_data, 128'hA0);
        checkVal("bp_stall0", stall_cnt, 0);
        in_data = 128'hA2; tick();
        checkVal("bp_stall1", stall_cnt, Perf ? 1 : 0);
        checkVal("bp_held", out_data, 128'hA0);
        tick();
        checkVal("bp_stall2", stall_cnt, Perf ? 2 : 0);
        out_ready = 1'b1; tick();
        checkVal("bp_a1", out_data, 128'hA1);
        checkVal("bp_occ_a1", occupancy, 1);
        checkVal("bp_rdy1", in_ready, 1);
        tick();
        checkVal("bp_a2", out_data, 128'hA2);
        in_valid = 1'b0; tick();
        checkVal("bp_empty", occupancy, 0);
        checkVal("bp_stall3", stall_cnt, Perf ? 3 : 0);

        // Flush while full, with an offered entry
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 128'hB0; tick();
        in_data = 128'hB1; tick();
        checkVal("fl_full", occupancy, 2);
        flush = 1'b1; in_data = 128'hB2; tick();
        checkVal("fl_occ0", occupancy, 0);
        checkVal("fl_vld0", out_valid, 0);
        checkVal("fl_cnt1", flush_cnt, Perf ? 1 : 0);
        flush = 1'b0; in_valid = 1'b0; tick();
        checkVal("fl_no_b2", out_valid, 0);
        checkVal("fl_rdy", in_ready, 1);
        // Flush with a genuinely accepted entry in the same cycle
        in_valid = 1'b1; in_data = 128'hB3; tick();
        flush = 1'b1; in_data = 128'hB4; tick();
        flush = 1'b0; in_valid = 1'b0; tick();
        checkVal("fl_drop_b4", occupancy, 0);
        checkVal("fl_cnt2", flush_cnt, Perf ? 2 : 0);
        checkVal("fl_stall4", stall_cnt, Perf ? 4 : 0);

        // Halt
        out_ready = 1'b1; in_valid = 1'b1;
        in_data = 128'hC0; tick();
        checkVal("h_c0", out_data, 128'hC0);
        in_data = 128'hC1; in_halt = 1'b1; tick();
        checkVal("h_c1", out_data, 128'hC1);
        checkVal("h_out_halt", out_halt, 1);
        checkVal("h_rdy0", in_ready, 0);
        checkVal("h_seen0", halt_seen, 0);
        in_data = 128'hC2; in_halt = 1'b0; tick();
        checkVal("h_seen1", halt_seen, 1);
        checkVal("h_occ0", occupancy, 0);
        tick();
        checkVal("h_no_c2", out_valid, 0);
        checkVal("h_rdy_blk", in_ready, 0);
        in_valid = 1'b0; flush = 1'b1; tick();
        flush = 1'b0;
        checkVal("h_seen_flush", halt_seen, 1);
        checkVal("h_flcnt", flush_cnt, Perf ? 2 : 0);
        checkVal("h_stall6", stall_cnt, Perf ? 6 : 0);

        // Async reset mid-flight
        RST = 1'b1; tick();
        RST = 1'b0; tick();
        checkVal("ar_rdy", in_ready, 1);
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 128'hE0; tick();
        in_data = 128'hE1; tick();
        checkVal("ar_full", occupancy, 2);
        in_valid = 1'b0;
        #2 RST = 1'b1;
        #1;
        checkVal("ar_vld0", out_valid, 0);
        checkVal("ar_occ0", occupancy, 0);
        checkVal("ar_rdy0", in_ready, 0);
        checkVal("ar_seen0", halt_seen, 0);
        checkVal("ar_cnt0", stall_cnt, 0);
        #1 RST = 1'b0;
        tick();
        checkVal("ar_rdy1", in_ready, 1);
        in_valid = 1'b1; in_data = 128'hD0; tick();
        checkVal("ar_d0", out_data, 128'hD0);
        checkVal("ar_v_d0", out_valid, 1);

        // Width extremes
        out_ready = 1'b1; in_data = '0;
        dataW1 = 1'b1; dataW1024 = {1024{1'b1}}; tick();
        checkVal("w1_ones", outW1, 1);
        checkVal("w1024_ones", $countones(outW1024), 1024);
        dataW1 = 1'b0; dataW1024 = '0; tick();
        checkVal("w1_zeros", outW1, 0);
        checkVal("w1024_zeros", $countones(outW1024), 0);
        dataW1024 = {512{2'b10}}; tick();
        checkVal("w1024_hi", outW1024[1023:896], {64{2'b10}});
        checkVal("w1024_lo", outW1024[127:0], {64{2'b10}});
        in_valid = 1'b0; tick();

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed-field inter-stage latches (EX/MEM and similar).
- Carries an opaque payload of DATA_W bits plus a halt flag through a 2-entry skid buffer with a valid/ready handshake, so upstream stalls are decoupled from downstream ready.
- Supports synchronous flush and sticky halt tracking.
- Drop-in between any two pipeline stages; the stage-specific field packing is done by the wrapper.

Parameters:
- DATA_W, 128, payload width in bits (packed control plus datapath fields), legal 1..1024.
- CNT_W, 32, width of performance counters (used only with PERF_CNT_EN).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  buffer can accept; registered, depends on state only.
- in_data  in  DATA_W  upstream payload.
- in_halt  in  1  entry is a HALT instruction.
- flush  in  1  discard all held entries this cycle.
- out_valid  out  1  head entry present.
- out_ready  in  1  downstream accepts head.
- out_data  out  DATA_W  head payload.
- out_halt  out  1  head halt flag.
- halt_seen  out  1  sticky: a halting entry has left the buffer.
- occupancy  out  2  entries held, 0..2.
- stall_cnt  out  CNT_W  cycles with in_valid=1 and in_ready=0.
- flush_cnt  out  CNT_W  flush cycles with occupancy>0.

Behaviour:
- Reset (async, RST=1): state EMPTY; out_valid=0; out_data=0; out_halt=0; in_ready=0 while RST=1, then 1 from the first edge after release; halt_seen=0; occupancy=0; counters=0.
- Storage: main register (head, drives out_*) and skid register. States:
  - EMPTY (occupancy 0)
  - ONE (main valid)
  - FULL (main and skid valid)
- Definitions: acc = in_valid & in_ready; deq = out_valid & out_ready.
- Transitions when flush=0:
  - EMPTY: acc -> ONE, and the payload appears on out_* the next cycle (latency 1).
  - ONE: acc & !deq -> FULL, new entry goes into skid. acc & deq -> ONE, main loads the new entry. !acc & deq -> EMPTY. Otherwise hold.
  - FULL: in_ready=0. deq -> ONE, skid moves to main. Otherwise hold.
- in_ready = (state != FULL) & !halt_seen & !halt_pending. It is registered and never combinationally dependent on out_ready.
- halt_pending is set when an entry with in_halt=1 is accepted, so nothing is accepted behind a halt. It is cleared by flush.
- halt_seen is set on deq with out_halt=1 and stays set until RST.
- flush=1: next state EMPTY, out_valid=0. Same-cycle acc is ignored and the entry is dropped. A same-cycle deq still counts as delivered, including setting halt_seen. Flush has priority over every other transition.
- out_data/out_halt are held stable while out_valid=1 and out_ready=0 (no change without deq).
- Ordering: entries leave in acceptance order; there is no reordering and no duplication.
- occupancy is combinational from state: 0, 1 or 2.
- Reset mid-operation: all entries are discarded immediately; there is no partial output.

Optional Feature:
- Macro: PIPE_STAGE_BUF_PERF_CNT_EN.
- Defined:
  - stall_cnt increments every cycle with in_valid=1 & in_ready=0.
  - flush_cnt increments every cycle with flush=1 & occupancy>0.
  - Both saturate at all-ones and reset to 0.
- Undefined: counter logic is not compiled; stall_cnt and flush_cnt are tied to 0. The ports remain.

Test Plan:
- Pass-through: RST released, out_ready=1, send 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 one cycle later each; occupancy never exceeds 1; in_ready stays 1.
- Backpressure: out_ready=0, send 0xA0,0xA1 -> occupancy=2, in_ready=0, out_data=0xA0 held; with 0xA2 still offered, stall_cnt=1 per cycle (PERF on). Raise out_ready -> 0xA0,0xA1,0xA2 delivered in order with no loss.
- Flush with simultaneous accept: FULL with 0xB0,0xB1, flush=1 plus in_valid with 0xB2 -> next cycle occupancy=0, out_valid=0; 0xB2 never appears; flush_cnt=1.
- Halt: send 0xC0, then 0xC1 with in_halt=1, then 0xC2 -> 0xC2 is not accepted (in_ready=0 after 0xC1). halt_seen=1 the cycle after 0xC1 dequeues, and stays 1 across later flush.
- Async reset mid-flight: FULL state, assert RST between edges -> out_valid=0, occupancy=0 immediately; after release the first accepted entry 0xD0 appears after 1 cycle.
- Width sweep: DATA_W=1 and DATA_W=1024, payload all-ones and all-zeros -> bit-exact on out_data.
